// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding lw/sw bridge between the core and a
// handshaked data memory. IDLE accepts a request, ACCESS drives the memory
// strobes until mem_ack or the timeout counter expires, RESP pulses the
// response for one cycle.
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned requests skip ACCESS
// and answer with resp_err=1 straight from IDLE.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        cnt;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              misaligned;
  logic              last_try;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
`else
  // Byte offset is deliberately ignored: the access goes to the enclosing word.
  assign misaligned = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  // Final ACCESS cycle before the timeout fires; an ack here still succeeds.
  assign last_try = (cnt == 8'd1);

  // State register; reset aborts any access in flight without a response.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; mem_ack is only looked at while in ACCESS.
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = misaligned ? RESP : ACCESS;
      ACCESS:  if (mem_ack || last_try) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            cnt     <= 8'(TIMEOUT);
            rdata_q <= '0;
            err_q   <= misaligned;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            rdata_q <= we_q ? 32'd0 : mem_rdata;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
            if (last_try) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state so reset clears them immediately.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_read   = (state == ACCESS) && !we_q;
    mem_write  = (state == ACCESS) &&  we_q;
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4, ADDR_W=10). Inputs change
// 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int passed = 0;

  load_store_unit #(.TIMEOUT(4), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Checks the idle/response-free output set shared by several steps.
  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rv"},    32'(resp_valid), 32'd0);
    check({tag, "_rd"},    32'(mem_read), 32'd0);
    check({tag, "_wr"},    32'(mem_write), 32'd0);
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    // Reset values
    mid();
    check_quiet("rst");
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err",   32'(resp_err), 32'd0);
    nxt();
    rst = 1'b0;

    // sw 0x10 <- DEADBEEF, ack on the third ACCESS cycle
    req(1'b1, 32'h10, 32'hDEADBEEF);
    mid(); check("sw_ready", 32'(req_ready), 32'd1);
    nxt(); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1'b1;
      mid();
      check("sw_wr",    32'(mem_write), 32'd1);
      check("sw_rd",    32'(mem_read), 32'd0);
      check("sw_addr",  32'(mem_addr), 32'd4);
      check("sw_wdata", mem_wdata, 32'hDEADBEEF);
      check("sw_busy",  32'(req_ready), 32'd0);
      check("sw_norv",  32'(resp_valid), 32'd0);
      nxt();
    end
    mem_ack = 1'b0;
    mid();
    check("sw_rv",    32'(resp_valid), 32'd1);
    check("sw_err",   32'(resp_err), 32'd0);
    check("sw_rdata", resp_rdata, 32'd0);
    check("sw_rsp_wr", 32'(mem_write), 32'd0);
    check("sw_rsp_busy", 32'(req_ready), 32'd0);
    nxt();
    mid(); check_quiet("sw_done");
    nxt();

    // lw 0x10 with immediate ack
    req(1'b0, 32'h10, 32'h0);
    nxt(); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    mid();
    check("lw_rd",   32'(mem_read), 32'd1);
    check("lw_wr",   32'(mem_write), 32'd0);
    check("lw_addr", 32'(mem_addr), 32'd4);
    nxt(); mem_ack = 1'b0; mem_rdata = 32'h0;
    mid();
    check("lw_rv",    32'(resp_valid), 32'd1);
    check("lw_rdata", resp_rdata, 32'hDEADBEEF);
    check("lw_err",   32'(resp_err), 32'd0);
    nxt();

    // lw 0x20, no ack: four read cycles then timeout
    req(1'b0, 32'h20, 32'h0);
    nxt(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("to_rd",   32'(mem_read), 32'd1);
      check("to_addr", 32'(mem_addr), 32'd8);
      check("to_norv", 32'(resp_valid), 32'd0);
      nxt();
    end
    mid();
    check("to_rv",    32'(resp_valid), 32'd1);
    check("to_err",   32'(resp_err), 32'd1);
    check("to_rdata", resp_rdata, 32'd0);
    check("to_rd_off", 32'(mem_read), 32'd0);
    nxt();

    // Ack in the final cycle before timeout wins
    req(1'b0, 32'h24, 32'h0);
    nxt(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h00001234; end
      mid(); check("aw_rd", 32'(mem_read), 32'd1);
      nxt();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    mid();
    check("aw_rv",    32'(resp_valid), 32'd1);
    check("aw_err",   32'(resp_err), 32'd0);
    check("aw_rdata", resp_rdata, 32'h00001234);
    nxt();

    // Stray ack while idle is ignored
    mem_ack = 1'b1;
    mid(); check_quiet("stray0");
    nxt();
    mid(); check_quiet("stray1");
    nxt(); mem_ack = 1'b0;

    // Reset pulse mid-ACCESS of a store
    req(1'b1, 32'h30, 32'hCAFEF00D);
    nxt(); req_valid = 1'b0;
    mid(); check("ra_wr", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("ra_wr_drop", 32'(mem_write), 32'd0);
    check("ra_addr0",   32'(mem_addr), 32'd0);
    check("ra_wdata0",  mem_wdata, 32'd0);
    check("ra_ready",   32'(req_ready), 32'd1);
    #1 rst = 1'b0;
    nxt();
    mid(); check_quiet("ra_after");
    req(1'b0, 32'h10, 32'h0);
    nxt(); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A55A5A;
    mid(); check("ra_lw_rd", 32'(mem_read), 32'd1);
    nxt(); mem_ack = 1'b0; mem_rdata = 32'h0;
    mid();
    check("ra_lw_rv",    32'(resp_valid), 32'd1);
    check("ra_lw_rdata", resp_rdata, 32'hA5A55A5A);
    nxt();

    // Misaligned lw 0x13
    req(1'b0, 32'h13, 32'h0);
    nxt(); req_valid = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mid();
    check("ma_rd",  32'(mem_read), 32'd0);
    check("ma_rv",  32'(resp_valid), 32'd1);
    check("ma_err", 32'(resp_err), 32'd1);
    check("ma_rdata", resp_rdata, 32'd0);
    nxt();
`else
    mem_ack = 1'b1; mem_rdata = 32'h13131313;
    mid();
    check("ma_rd",   32'(mem_read), 32'd1);
    check("ma_addr", 32'(mem_addr), 32'd4);
    nxt(); mem_ack = 1'b0;
    mid();
    check("ma_rv",    32'(resp_valid), 32'd1);
    check("ma_err",   32'(resp_err), 32'd0);
    check("ma_rdata", resp_rdata, 32'h13131313);
    nxt();
`endif

    // req_valid held high: sw then lw, ack always high
    req(1'b1, 32'h40, 32'h11112222);
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    mid(); check("b2b_acc1", 32'(req_ready), 32'd1);
    nxt(); req_we = 1'b0; req_addr = 32'h44;
    mid();
    check("b2b_wr1",  32'(mem_write), 32'd1);
    check("b2b_rd1",  32'(mem_read), 32'd0);
    check("b2b_busy1", 32'(req_ready), 32'd0);
    check("b2b_addr1", 32'(mem_addr), 32'h10);
    nxt();
    mid();
    check("b2b_rv1",   32'(resp_valid), 32'd1);
    check("b2b_busy2", 32'(req_ready), 32'd0);
    check("b2b_ovl1",  32'(mem_read & mem_write), 32'd0);
    nxt();
    mid(); check("b2b_acc2", 32'(req_ready), 32'd1);
    check("b2b_norv", 32'(resp_valid), 32'd0);
    nxt(); req_valid = 1'b0;
    mid();
    check("b2b_rd2",   32'(mem_read), 32'd1);
    check("b2b_wr2",   32'(mem_write), 32'd0);
    check("b2b_addr2", 32'(mem_addr), 32'h11);
    nxt(); mem_ack = 1'b0;
    mid();
    check("b2b_rv2",    32'(resp_valid), 32'd1);
    check("b2b_rdata2", resp_rdata, 32'h33334444);
    nxt();
    mid(); check_quiet("b2b_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
